parameter_bank: RTL and testbench
=================================

PARAMETER_BANK -- requirements
Module: parameter_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 36, bit width of one parameter word.
REQ-002 The block SHALL have parameter NUM_PARAMS, default 4, number of parameter entries (legal range 1..2**ADDR_BITS).
REQ-003 The block SHALL have parameter ADDR_BITS, default 2, width of read and write addresses (minimum 1).
REQ-004 The block SHALL have parameter RESET_VALUE, default 0, DATA_WIDTH-bit value loaded into every entry at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port buffer_switch_event, input, 1 bit: frame-boundary strobe, one cycle per event.
REQ-008 The block SHALL have port write_enable, input, 1 bit: qualifies write_addr and write_data.
REQ-009 The block SHALL have port write_addr, input, ADDR_BITS: shadow entry index.
REQ-010 The block SHALL have port write_data, input, DATA_WIDTH: value for the shadow entry.
REQ-011 The block SHALL have port commit, input, 1 bit: writer marks the shadow set complete.
REQ-012 The block SHALL have port read_addr, input, ADDR_BITS: active entry index.
REQ-013 The block SHALL have port read_data, output, DATA_WIDTH: active entry at read_addr.
REQ-014 The block SHALL have port read_data_all, output, NUM_PARAMS*DATA_WIDTH: all active entries, entry i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 The block SHALL have port pending, output, 1 bit: committed shadow set awaiting a switch event.
REQ-016 The block SHALL have port dirty, output, 1 bit: shadow written since the last swap.
REQ-017 The block SHALL have port swap_done, output, 1 bit: one-cycle pulse, active set updated.
REQ-018 The block SHALL have port swap_skipped, output, 1 bit: one-cycle pulse, switch event arrived with dirty=1 and pending=0.

Function
REQ-019 Storage SHALL be two register arrays, shadow and active, each NUM_PARAMS x DATA_WIDTH.
REQ-020 A cycle with write_enable=1 and write_addr<NUM_PARAMS SHALL write write_data into shadow[write_addr] and set dirty on the next edge.
REQ-021 Writes with write_addr>=NUM_PARAMS SHALL be ignored, with no state change.
REQ-022 commit=1 SHALL set pending on the next edge, whether or not dirty is set.
REQ-023 Writes while pending=1 SHALL be accepted and become part of the pending set.
REQ-024 A cycle with buffer_switch_event=1 and pending=1 (registered value) SHALL, on that edge, do all of the following:
 - copy every shadow entry into active, using shadow contents from before that edge;
 - clear pending and dirty;
 - assert swap_done for exactly the following cycle.
REQ-025 Shadow SHALL keep its contents after a swap (copy, not pointer exchange), so the next set may be a partial update.
REQ-026 A cycle with buffer_switch_event=1, pending=0 and dirty=1 SHALL leave active unchanged and pulse swap_skipped for one cycle.
REQ-027 A cycle with buffer_switch_event=1, pending=0 and dirty=0 SHALL have no effect.
REQ-028 Simultaneous write and swap in one cycle:
 - the swap SHALL copy the pre-write shadow;
 - the write SHALL land in shadow;
 - dirty SHALL be 1 after the edge.
REQ-029 Simultaneous commit and swap-eligible switch event in one cycle:
 - the swap SHALL proceed;
 - pending SHALL be 1 after the edge, because the commit re-arms.
REQ-030 Simultaneous commit and switch event with pending=0 SHALL NOT swap in that cycle, and pending SHALL be 1 after the edge.
REQ-031 read_data SHALL be combinational from active[read_addr] with zero latency, and SHALL be 0 when read_addr>=NUM_PARAMS.
REQ-032 read_data and read_data_all SHALL change only on a swap edge or on reset.

Reset
REQ-033 While rst=1, all shadow and active entries SHALL be RESET_VALUE, and pending, dirty, swap_done and swap_skipped SHALL be 0, regardless of clk.
REQ-034 Reset asserted mid-operation SHALL discard any pending set, with no swap occurring.
REQ-035 The first edge after rst deasserts SHALL process inputs normally.

Verification
REQ-036 Scenario reset: after reset, read_data_all = all RESET_VALUE; pending = 0, dirty = 0.
REQ-037 Scenario basic swap:
 - stimulus: write entries 0..3 = 0x1,0x2,0x3,0x4; commit; switch event;
 - response: swap_done pulses once; read_data_all = {0x4,0x3,0x2,0x1}; pending = 0, dirty = 0.
REQ-038 Scenario no commit: write entry 1 = 0xABC; switch event without commit -> swap_skipped pulses; read_data(1) keeps its old value; dirty stays 1.
REQ-039 Scenario same-cycle write and swap:
 - stimulus: entry 2 pending = 0x55; write entry 2 = 0x77 in the switch cycle;
 - response: active[2] = 0x55; shadow[2] = 0x77; dirty = 1.
REQ-040 Scenario out of range: with NUM_PARAMS=3, write address 3 -> no state change; read_addr=3 -> read_data = 0.
REQ-041 Scenario reset mid-operation: commit; assert rst before the switch event -> no swap_done; all entries = RESET_VALUE.

Source files
------------

// File: rtl/parameter_bank.sv
// Double-buffered parameter bank: the writer fills a shadow set, commits it, and the
// active set takes a full copy of shadow on the next frame-boundary strobe.
module parameter_bank #(
  parameter int                    DATA_WIDTH  = 36,
  parameter int                    NUM_PARAMS  = 4,
  parameter int                    ADDR_BITS   = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             buffer_switch_event,
  input  logic                             write_enable,
  input  logic [ADDR_BITS-1:0]             write_addr,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             commit,
  input  logic [ADDR_BITS-1:0]             read_addr,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic [NUM_PARAMS*DATA_WIDTH-1:0] read_data_all,
  output logic                             pending,
  output logic                             dirty,
  output logic                             swap_done,
  output logic                             swap_skipped
);

  // One extra bit so that NUM_PARAMS == 2**ADDR_BITS stays representable.
  localparam logic [ADDR_BITS:0] NUM_ENTRIES = NUM_PARAMS[ADDR_BITS:0];

  logic [DATA_WIDTH-1:0] shadow_q [NUM_PARAMS];
  logic [DATA_WIDTH-1:0] shadow_d [NUM_PARAMS];
  logic [DATA_WIDTH-1:0] active_q [NUM_PARAMS];
  logic [DATA_WIDTH-1:0] active_d [NUM_PARAMS];
  logic pending_q, pending_d;
  logic dirty_q, dirty_d;
  logic swap_done_q, swap_done_d;
  logic swap_skipped_q, swap_skipped_d;
  logic write_ok;
  logic swap_go;

  always_comb begin
    write_ok       = write_enable && ({1'b0, write_addr} < NUM_ENTRIES);
    swap_go        = buffer_switch_event && pending_q;
    shadow_d       = shadow_q;
    active_d       = active_q;
    pending_d      = pending_q;
    dirty_d        = dirty_q;
    swap_done_d    = 1'b0;
    swap_skipped_d = 1'b0;

    // The copy reads shadow_q, so a same-cycle write is not part of this swap.
    if (swap_go) begin
      active_d    = shadow_q;
      pending_d   = 1'b0;
      dirty_d     = 1'b0;
      swap_done_d = 1'b1;
    end else if (buffer_switch_event && dirty_q) begin
      swap_skipped_d = 1'b1;
    end

    if (write_ok) begin
      shadow_d[write_addr] = write_data;
      dirty_d              = 1'b1;
    end

    // Commit re-arms even when it coincides with a swap.
    if (commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q       <= '{default: RESET_VALUE};
      active_q       <= '{default: RESET_VALUE};
      pending_q      <= 1'b0;
      dirty_q        <= 1'b0;
      swap_done_q    <= 1'b0;
      swap_skipped_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      dirty_q        <= dirty_d;
      swap_done_q    <= swap_done_d;
      swap_skipped_q <= swap_skipped_d;
    end
  end

  always_comb begin
    read_data = '0;
    if ({1'b0, read_addr} < NUM_ENTRIES) begin
      read_data = active_q[read_addr];
    end
  end

  always_comb begin
    read_data_all = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      read_data_all[i*DATA_WIDTH +: DATA_WIDTH] = active_q[i];
    end
  end

  assign pending      = pending_q;
  assign dirty        = dirty_q;
  assign swap_done    = swap_done_q;
  assign swap_skipped = swap_skipped_q;

endmodule

// File: tb/tb_parameter_bank.sv
// Directed bench for parameter_bank: a 4-entry bank and a 3-entry bank share stimulus,
// the 3-entry one covering out-of-range addresses.
module tb_parameter_bank;

  localparam int          W  = 36;
  localparam logic [35:0] RV = 36'hA_5A5A_5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          ev, we, cm;
  logic [1:0]    wa, ra;
  logic [35:0]   wd;
  logic [35:0]   rd4, rd3;
  logic [143:0]  all4;
  logic [107:0]  all3;
  logic          pend4, dirty4, done4, skip4;
  logic          pend3, dirty3, done3, skip3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parameter_bank #(.DATA_WIDTH(W), .NUM_PARAMS(4), .ADDR_BITS(2), .RESET_VALUE(RV)) dut4 (
    .clk(clk), .rst(rst), .buffer_switch_event(ev), .write_enable(we), .write_addr(wa),
    .write_data(wd), .commit(cm), .read_addr(ra), .read_data(rd4), .read_data_all(all4),
    .pending(pend4), .dirty(dirty4), .swap_done(done4), .swap_skipped(skip4));

  parameter_bank #(.DATA_WIDTH(W), .NUM_PARAMS(3), .ADDR_BITS(2), .RESET_VALUE(RV)) dut3 (
    .clk(clk), .rst(rst), .buffer_switch_event(ev), .write_enable(we), .write_addr(wa),
    .write_data(wd), .commit(cm), .read_addr(ra), .read_data(rd3), .read_data_all(all3),
    .pending(pend3), .dirty(dirty3), .swap_done(done3), .swap_skipped(skip3));

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, clock it, then return inputs to idle.
  task automatic step(input logic s_we, input logic [1:0] s_wa, input logic [35:0] s_wd,
                      input logic s_cm, input logic s_ev);
    we = s_we; wa = s_wa; wd = s_wd; cm = s_cm; ev = s_ev;
    tick();
    we = 1'b0; wa = 2'd0; wd = '0; cm = 1'b0; ev = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ev = 1'b0; we = 1'b0; cm = 1'b0; wa = 2'd0; wd = '0; ra = 2'd0;

    // Async reset must take effect before any clock edge.
    #2;
    chk("rst_all4", all4, {4{RV}});
    chk("rst_all3", all3, {3{RV}});
    chk("rst_flags", {pend4, dirty4, done4, skip4}, 4'b0000);
    tick();
    tick();
    rst = 1'b0;

    // Basic swap
    step(1'b1, 2'd0, 36'h1, 1'b0, 1'b0);
    chk("wr_dirty", dirty4, 1'b1);
    step(1'b1, 2'd1, 36'h2, 1'b0, 1'b0);
    step(1'b1, 2'd2, 36'h3, 1'b0, 1'b0);
    step(1'b1, 2'd3, 36'h4, 1'b0, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    chk("commit_pend", pend4, 1'b1);
    chk("pre_swap_all", all4, {4{RV}});
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("swap_done", done4, 1'b1);
    chk("swap_flags", {pend4, dirty4, skip4}, 3'b000);
    chk("swap_all4", all4, {36'h4, 36'h3, 36'h2, 36'h1});
    chk("swap_all3", all3, {36'h3, 36'h2, 36'h1});
    ra = 2'd2; #1;
    chk("rd_addr2", rd4, 36'h3);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b0);
    chk("done_one_cycle", done4, 1'b0);

    // No commit: switch event is skipped
    step(1'b1, 2'd1, 36'hABC, 1'b0, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("skip_pulse", {skip4, done4}, 2'b10);
    ra = 2'd1; #1;
    chk("skip_rd1", rd4, 36'h2);
    chk("skip_dirty", dirty4, 1'b1);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b0);
    chk("skip_one_cycle", skip4, 1'b0);

    // Same-cycle write and swap
    step(1'b1, 2'd2, 36'h55, 1'b0, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    step(1'b1, 2'd2, 36'h77, 1'b0, 1'b1);
    chk("wsw_done", done4, 1'b1);
    chk("wsw_all", all4, {36'h4, 36'h55, 36'hABC, 36'h1});
    chk("wsw_flags", {pend4, dirty4}, 2'b01);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("shadow_kept", all4, {36'h4, 36'h77, 36'hABC, 36'h1});
    chk("shadow_kept3", all3, {36'h77, 36'hABC, 36'h1});
    chk("clean_flags", {pend4, dirty4}, 2'b00);

    // Commit with switch event while not pending: no swap, pending armed
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b1);
    chk("cmev_nopend", {done4, skip4, pend4}, 3'b001);
    step(1'b1, 2'd0, 36'h11, 1'b0, 1'b0);
    chk("hold_all", all4, {36'h4, 36'h77, 36'hABC, 36'h1});
    // Commit with eligible switch: swap and re-arm
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b1);
    chk("cmev_pend", {done4, pend4, dirty4}, 3'b110);
    chk("cmev_all", all4, {36'h4, 36'h77, 36'hABC, 36'h11});
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("rearm_swap", {done4, pend4}, 2'b10);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("idle_event", {done4, skip4, pend4, dirty4}, 4'b0000);

    // Out-of-range write on the 3-entry bank
    step(1'b1, 2'd3, 36'hFFF, 1'b0, 1'b0);
    chk("oor_dirty3", dirty3, 1'b0);
    chk("oor_dirty4", dirty4, 1'b1);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("oor_all3", all3, {36'h77, 36'hABC, 36'h11});
    ra = 2'd3; #1;
    chk("oor_rd3", rd3, 36'h0);
    chk("in_rd4", rd4, 36'hFFF);

    // Reset mid-operation discards the pending set
    step(1'b1, 2'd0, 36'h99, 1'b0, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    chk("mid_pend", pend4, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_all", all4, {4{RV}});
    chk("mid_rst_flags", {pend4, dirty4, done4, skip4}, 4'b0000);
    ev = 1'b1;
    tick();
    chk("rst_no_swap", {done4, all4}, {1'b0, {4{RV}}});
    rst = 1'b0;
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("post_rst_ev", {done4, skip4, pend4}, 3'b000);
    step(1'b0, 2'd0, 36'h0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 36'h0, 1'b0, 1'b1);
    chk("post_rst_swap", {done4, all4}, {1'b1, {4{RV}}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
